vs_sci_vol_writer: RTL and testbench
====================================

Name: vs_sci_vol_writer

Overview:
Downstream consumer of the Bluetooth command decoder's volume and pause outputs. Keeps the VS10xx decoder's SCI_VOL register in step with the requested volume by issuing SCI write frames over a mode-0 SPI link. Writes only when the target value differs from the last value written. Waits for the decoder's DREQ before starting each frame.

Parameters:
SCK_HALF, 25, clk cycles per SCK half-period; minimum 2 (gives 1 MHz SCK at 50 MHz)
VOL_ADDR, 8'h0B, SCI register address written
MUTE_VOL, 16'hFEFE, value written while paused

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
i_vol  input  16  requested SCI_VOL value {left,right}; 0 = loudest
i_pause  input  1  1 = mute (target becomes MUTE_VOL)
i_dreq  input  1  decoder DREQ, asynchronous, 1 = ready
o_xcs  output  1  SCI chip select, active low
o_sck  output  1  SPI clock, idles low
o_mosi  output  1  serial data, MSB first
o_busy  output  1  1 from frame start until the end of GAP
o_done  output  1  one-cycle pulse when a frame's CS_HOLD ends

Behaviour:
- Reset (rst=1 at a clk edge, highest priority, including mid-frame): o_xcs=1, o_sck=0, o_mosi=0, o_busy=0, o_done=0, FSM=IDLE, bit counter=0, divider=0, DREQ synchroniser=0. The pending flag is set so that one write happens after reset.
- Target: tgt = i_pause ? MUTE_VOL : i_vol, evaluated combinationally.
- Shadow register: holds the last written value. The pending flag is set whenever tgt != shadow in IDLE.
- DREQ: passes through a 2-flop synchroniser. Only dreq_s is used.
- FSM states:
  - IDLE: if (pending or tgt!=shadow) and dreq_s=1, latch frame = {8'h02, VOL_ADDR, tgt} (32 bits). Then shadow<=tgt, clear pending, o_busy<=1, go to SETUP.
    - If dreq_s=0, stay in IDLE. Re-evaluate tgt every cycle, so only the newest value is sent.
  - SETUP: o_xcs=0, o_sck=0, o_mosi=frame[31]. Lasts SCK_HALF cycles, then go to SHIFT.
  - SHIFT: 32 bits, each 2*SCK_HALF cycles.
    - First half: SCK=0, MOSI = current bit.
    - Second half: SCK=1.
    - MOSI changes only while SCK is low. The decoder samples on the rising edge.
    - After bit 0's high half, go to HOLD.
  - HOLD: o_sck=0, o_xcs=0, SCK_HALF cycles. On exit, o_xcs<=1, o_done pulses for one cycle, go to GAP.
  - GAP: o_xcs=1 for 2*SCK_HALF cycles, then o_busy<=0, go to IDLE.
- o_xcs is low for exactly (66*SCK_HALF) cycles per frame.
- Total IDLE-to-IDLE time = 68*SCK_HALF + 1 cycles.
- Changes to i_vol or i_pause during a frame do not alter the frame in flight. On return to IDLE, tgt!=shadow triggers the next frame.
- Simultaneous pause toggle and volume change: both are folded into the single tgt value.
- Pause then unpause before the next IDLE, with i_vol unchanged: tgt==shadow, so no frame is sent.
- DREQ dropping mid-frame is ignored. DREQ is checked only at frame start.
- The divider and bit counters are sized for SCK_HALF up to 2^16-1. There is no wrap-around inside a frame.

Test Plan:
- SCK_HALF=2, i_vol=16'h0000, i_pause=0, i_dreq=1, release rst → one frame. The MOSI bits captured on SCK rising edges equal 32'h020B0000. o_xcs is low for 132 cycles, there are 32 SCK rising edges, and o_done pulses once. No second frame follows.
- Idle at shadow=16'h0000; set i_vol=16'h1C1C → one frame 32'h020B1C1C. Hold i_vol for 1000 cycles → no further o_xcs activity.
- i_pause 0→1 → frame 32'h020BFEFE. Then i_pause 1→0 → frame 32'h020B1C1C. Pulse i_pause high for 3 cycles during a frame, with i_vol unchanged → no extra frame.
- i_dreq=0, change i_vol to 16'h3838 then to 16'h5454 → o_xcs stays 1. Raise i_dreq → exactly one frame, 32'h020B5454, starting within 3 cycles of dreq_s rising.
- Change i_vol from 16'h0E0E to 16'h2A2A at bit 10 of a frame → the current frame completes as 32'h020B0E0E. After GAP, a frame 32'h020B2A2A follows.
- Assert rst at bit 20 of a frame → the next cycle shows o_xcs=1, o_sck=0, o_busy=0. After release, a full frame for the current tgt is sent.

Source files
------------

// File: rtl/vs_sci_vol_writer.sv
// VS10xx SCI_VOL writer: mirrors the requested volume (or mute level) into the
// decoder with a single 32-bit SCI write over a mode-0 SPI link when it changes.
module vs_sci_vol_writer #(
   parameter int          SCK_HALF = 25,
   parameter logic [7:0]  VOL_ADDR = 8'h0B,
   parameter logic [15:0] MUTE_VOL = 16'hFEFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_vol,
   input  logic        i_pause,
   input  logic        i_dreq,
   output logic        o_xcs,
   output logic        o_sck,
   output logic        o_mosi,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   // Divider is one bit wider than 16 so the GAP count (2*SCK_HALF) never wraps.
   localparam logic [16:0] HALF_LAST = 17'(SCK_HALF - 1);
   localparam logic [16:0] GAP_LAST  = 17'(2 * SCK_HALF - 1);

   state_t      r_state, w_state_nxt;
   logic [16:0] r_div, w_div_nxt;
   logic [4:0]  r_bit, w_bit_nxt;
   logic        r_half, w_half_nxt;
   logic [31:0] r_frame, w_frame_nxt;
   logic [15:0] r_shadow;
   logic        r_pending;
   logic        r_dreq_m, r_dreq_s;
   logic        r_xcs, r_sck, r_mosi, r_busy, r_done;

   logic [15:0] w_tgt;
   logic        w_diff, w_half_last, w_load;
   logic        w_xcs_nxt, w_sck_nxt, w_mosi_nxt, w_busy_nxt, w_done_nxt;

   always_comb begin
      w_tgt       = i_pause ? MUTE_VOL : i_vol;
      w_diff      = (w_tgt != r_shadow);
      w_half_last = (r_div == HALF_LAST);
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_half_nxt  = r_half;
      w_load      = 1'b0;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if ((r_pending || w_diff) && r_dreq_s) begin
               w_load      = 1'b1;
               w_state_nxt = S_SETUP;
               w_div_nxt   = '0;
               w_bit_nxt   = 5'd31;
               w_half_nxt  = 1'b0;
            end
         end
         S_SETUP: begin
            w_div_nxt = r_div + 17'd1;
            if (w_half_last) begin
               w_div_nxt   = '0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_div_nxt = r_div + 17'd1;
            if (w_half_last) begin
               w_div_nxt = '0;
               if (!r_half) begin
                  w_half_nxt = 1'b1;
               end else if (r_bit == 5'd0) begin
                  w_half_nxt  = 1'b0;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_half_nxt = 1'b0;
                  w_bit_nxt  = r_bit - 5'd1;
               end
            end
         end
         S_HOLD: begin
            w_div_nxt = r_div + 17'd1;
            if (w_half_last) begin
               w_div_nxt   = '0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            w_div_nxt = r_div + 17'd1;
            if (r_div == GAP_LAST) begin
               w_div_nxt   = '0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_frame_nxt = w_load ? {8'h02, VOL_ADDR, w_tgt} : r_frame;

      // Outputs are registered from the next state so the pins never glitch.
      w_xcs_nxt  = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT) ||
                     (w_state_nxt == S_HOLD));
      w_sck_nxt  = (w_state_nxt == S_SHIFT) && w_half_nxt;
      w_mosi_nxt = ((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT)) ?
                   w_frame_nxt[w_bit_nxt] : 1'b0;
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_bit     <= '0;
         r_half    <= 1'b0;
         r_frame   <= '0;
         r_shadow  <= '0;
         r_pending <= 1'b1;
         r_dreq_m  <= 1'b0;
         r_dreq_s  <= 1'b0;
         r_xcs     <= 1'b1;
         r_sck     <= 1'b0;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_div    <= w_div_nxt;
         r_bit    <= w_bit_nxt;
         r_half   <= w_half_nxt;
         r_frame  <= w_frame_nxt;
         r_dreq_m <= i_dreq;
         r_dreq_s <= r_dreq_m;
         r_xcs    <= w_xcs_nxt;
         r_sck    <= w_sck_nxt;
         r_mosi   <= w_mosi_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         if (w_load) begin
            r_shadow  <= w_tgt;
            r_pending <= 1'b0;
         end else if ((r_state == S_IDLE) && w_diff) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign o_xcs  = r_xcs;
   assign o_sck  = r_sck;
   assign o_mosi = r_mosi;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_vs_sci_vol_writer.sv
// Bench for vs_sci_vol_writer: an SPI monitor rebuilds each SCI frame and
// compares it with the expected-frame queue filled by the scenario tasks.
module tb_vs_sci_vol_writer;

   localparam int HALF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] i_vol = 16'h0000;
   logic        i_pause = 1'b0;
   logic        i_dreq = 1'b1;
   logic        o_xcs, o_sck, o_mosi, o_busy, o_done;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   int          frame_cnt = 0;
   int          bits = 0;
   int          low_cnt = 0;
   logic        in_frame = 1'b0;
   logic        prev_sck = 1'b0;
   logic [31:0] word = '0;

   vs_sci_vol_writer #(.SCK_HALF(HALF), .VOL_ADDR(8'h0B), .MUTE_VOL(16'hFEFE)) dut (
      .clk(clk), .rst(rst), .i_vol(i_vol), .i_pause(i_pause), .i_dreq(i_dreq),
      .o_xcs(o_xcs), .o_sck(o_sck), .o_mosi(o_mosi), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   // Frame monitor: samples on the falling edge, captures MOSI at each SCK rise.
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         prev_sck = 1'b0;
      end else begin
         if (!o_xcs && !in_frame) begin
            in_frame = 1'b1;
            low_cnt  = 0;
            bits     = 0;
            word     = '0;
         end
         if (in_frame && !o_xcs) begin
            low_cnt++;
            if (o_sck && !prev_sck) begin
               word = {word[30:0], o_mosi};
               bits++;
            end
         end else if (in_frame && o_xcs) begin
            in_frame = 1'b0;
            frame_cnt++;
            checks += 4;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected: got %h, no frame expected", word);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (word !== e) begin
                  errors++;
                  $display("FAIL frame_word: got %h expected %h", word, e);
               end
            end
            if (bits !== 32) begin
               errors++;
               $display("FAIL frame_bits: got %0d expected 32", bits);
            end
            if (low_cnt !== 66 * HALF) begin
               errors++;
               $display("FAIL xcs_low_cycles: got %0d expected %0d", low_cnt, 66 * HALF);
            end
            if (o_done !== 1'b1) begin
               errors++;
               $display("FAIL done_at_cs_rise: got %b expected 1", o_done);
            end
         end
         prev_sck = o_sck;
      end
   end

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while (!(frame_cnt >= target && !o_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL frame_timeout: frames %0d expected %0d", frame_cnt, target);
      end
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      while (!o_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_bits(input int nb);
      int n;
      n = 0;
      while (!(in_frame && bits >= nb) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL bit_wait_timeout: bits %0d expected %0d", bits, nb);
      end
   endtask

   task automatic check_quiet(input int cycles, input int fc, input string name);
      repeat (cycles) @(negedge clk);
      checks++;
      if (frame_cnt !== fc || in_frame || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: frames %0d expected %0d, queue %0d", name, frame_cnt, fc, exp_q.size());
      end
   endtask

   task automatic test_reset();
      int fc;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_xcs, o_sck, o_mosi, o_busy, o_done} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 10000", {o_xcs, o_sck, o_mosi, o_busy, o_done});
      end
      fc = frame_cnt;
      exp_q.push_back(32'h020B0000);
      rst = 1'b0;
      wait_frames(fc + 1);
      check_quiet(300, fc + 1, "reset_single_frame");
   endtask

   task automatic test_vol_change();
      int fc;
      fc = frame_cnt;
      exp_q.push_back(32'h020B1C1C);
      i_vol = 16'h1C1C;
      wait_frames(fc + 1);
      check_quiet(1000, fc + 1, "vol_hold_quiet");
   endtask

   task automatic test_pause();
      int fc;
      fc = frame_cnt;
      exp_q.push_back(32'h020BFEFE);
      i_pause = 1'b1;
      wait_frames(fc + 1);
      exp_q.push_back(32'h020B1C1C);
      i_pause = 1'b0;
      wait_frames(fc + 2);
      exp_q.push_back(32'h020B7070);
      i_vol = 16'h7070;
      wait_busy();
      repeat (10) @(negedge clk);
      i_pause = 1'b1;
      repeat (3) @(negedge clk);
      i_pause = 1'b0;
      wait_frames(fc + 3);
      check_quiet(400, fc + 3, "pause_pulse_no_frame");
   endtask

   task automatic test_dreq();
      int fc, lat;
      fc = frame_cnt;
      i_dreq = 1'b0;
      repeat (5) @(negedge clk);
      i_vol = 16'h3838;
      repeat (20) @(negedge clk);
      i_vol = 16'h5454;
      check_quiet(200, fc, "dreq_low_quiet");
      checks++;
      if (o_xcs !== 1'b1) begin
         errors++;
         $display("FAIL dreq_low_xcs: got %b expected 1", o_xcs);
      end
      exp_q.push_back(32'h020B5454);
      i_dreq = 1'b1;
      lat = 0;
      while (o_xcs && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      // Two synchroniser stages plus at most three cycles to the frame start.
      checks++;
      if (lat > 5) begin
         errors++;
         $display("FAIL dreq_latency: got %0d cycles expected <= 5", lat);
      end
      wait_frames(fc + 1);
      check_quiet(300, fc + 1, "dreq_single_frame");
   endtask

   task automatic test_midframe_change();
      int fc;
      fc = frame_cnt;
      exp_q.push_back(32'h020B0E0E);
      i_vol = 16'h0E0E;
      wait_bits(10);
      exp_q.push_back(32'h020B2A2A);
      i_vol = 16'h2A2A;
      wait_frames(fc + 2);
      check_quiet(300, fc + 2, "midframe_two_frames");
   endtask

   task automatic test_reset_midframe();
      int fc;
      logic [31:0] dropped;
      fc = frame_cnt;
      exp_q.push_back(32'h020B4646);
      i_vol = 16'h4646;
      wait_bits(20);
      dropped = exp_q.pop_front();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_xcs, o_sck, o_busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_midframe: got xcs/sck/busy %b expected 100", {o_xcs, o_sck, o_busy});
      end
      rst = 1'b0;
      exp_q.push_back(dropped);
      wait_frames(fc + 1);
      check_quiet(300, fc + 1, "reset_midframe_refresh");
   endtask

   initial begin
      test_reset();
      test_vol_change();
      test_pause();
      test_dreq();
      test_midframe_change();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
